// File: rtl/rv_pkg.sv
// Shared fetch-path types: datapath widths, reset PC default, fetch FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IDLE: no request; REQ: fetching at fetch_pc; DROP: waiting out a stale request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // One buffered fetch result: the word and the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Next sequential word address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush; head data read combinationally from storage.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push accepted when not full or when popping; pop from empty ignored.
module ifq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Pointer and occupancy update; flush empties without touching storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (reset && !i_flush && w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Upstream only requests when a slot is guaranteed, so this never fires.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(i_push && !i_flush && o_full && !w_pop));

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the PC, issues single-outstanding word requests, buffers results.
// Latency: first request 1 cycle after reset release, first instruction 1 cycle later.
// Backpressure: stops requesting when the buffer has no free slot; redirect flushes.
module ifetch_queue
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pcplus4,
  input  logic            instr_ready
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] w_addr_nxt;
  logic            r_req;

  logic [XLEN-1:0] w_target;
  logic            w_xfer;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_count_after;
  logic            w_full;
  logic            w_empty;
  fetch_entry_t    w_push_dat;
  fetch_entry_t    w_head;

  assign w_target = redirect_pc & ~XLEN'(3);
  assign w_xfer   = r_req && imem_ready;

  // Redirect squashes both the incoming word and any pop of the doomed head.
  assign w_flush  = redirect;
  assign w_push   = (r_state == REQ) && w_xfer && !redirect;
  assign w_pop    = !w_empty && instr_ready && !redirect;

  assign w_push_dat.pc    = r_fetch_pc;
  assign w_push_dat.instr = imem_rdata;

  assign w_count_after = {1'b0, w_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};

  ifq_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (w_flush),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Next state, next PC and next request address; the address only moves when
  // no request is left dangling, so it stays stable across a stall.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_addr_nxt     = r_addr;
    if (redirect) begin
      w_fetch_pc_nxt = w_target;
      if (r_state == IDLE || w_xfer) begin
        w_state_nxt = REQ;
        w_addr_nxt  = w_target;
      end else begin
        w_state_nxt = DROP;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_full) begin
            w_state_nxt = REQ;
            w_addr_nxt  = r_fetch_pc;
          end
        end
        REQ: begin
          if (w_xfer) begin
            w_fetch_pc_nxt = pc_step(r_fetch_pc);
            w_addr_nxt     = pc_step(r_fetch_pc);
            w_state_nxt    = (w_count_after < DEPTH_W) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (w_xfer) begin
            w_state_nxt = REQ;
            w_addr_nxt  = r_fetch_pc;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Fetch state, PC and registered request outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_req      <= (w_state_nxt != IDLE);
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;

  // Head fields read as zero while empty so decode never sees stale storage.
  assign instr_valid   = !w_empty;
  assign instr         = instr_valid ? w_head.instr : '0;
  assign instr_pc      = instr_valid ? w_head.pc : '0;
  assign instr_pcplus4 = instr_valid ? pc_step(w_head.pc) : '0;

endmodule
